// File: rtl/hsv_threshold_quantizer_pkg.sv
// Shared definitions for the HSV threshold quantizer.
//   - channel and pixel-counter widths
//   - reset values of the active masks (shared with the threshold block)
//   - hsv_t: one 8-bit value per channel
//   - center_bias(): midpoint of the LSB range that a mask drops
package hsv_threshold_quantizer_pkg;

  localparam int CH_W  = 8;
  localparam int CNT_W = 20;

  localparam logic [CH_W-1:0] H_RST_MASK_DEF = 8'hE0;
  localparam logic [CH_W-1:0] S_RST_MASK_DEF = 8'hC0;
  localparam logic [CH_W-1:0] V_RST_MASK_DEF = 8'hC0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CH_W-1:0] h;
    logic [CH_W-1:0] s;
    logic [CH_W-1:0] v;
  } hsv_t;

  // ((~mask) + 1) >> 1, carried in CH_W+1 bits so that mask = 0 gives 0x80.
  // Non-contiguous masks go through the same formula unchanged.
  function automatic logic [CH_W-1:0] center_bias(input logic [CH_W-1:0] mask);
    logic [CH_W:0] span;
    span = {1'b0, ~mask} + {{CH_W{1'b0}}, 1'b1};
    return span[CH_W:1];
  endfunction

endpackage

// File: rtl/hsv_quant_channel.sv
// Combinational quantizer for a single channel.
//   pix   : channel value (may already be masked)
//   mask  : leading-ones mask applied to this beat
//   quant : (pix & mask) | bias. The bias re-centres the value within the
//           dropped LSB range when CENTER_EN = 1, and is 0 otherwise.
module hsv_quant_channel
  import hsv_threshold_quantizer_pkg::*;
#(
  parameter bit CENTER_EN = 1'b1
) (
  input  logic [CH_W-1:0] pix,
  input  logic [CH_W-1:0] mask,
  output logic [CH_W-1:0] quant
);

  logic [CH_W-1:0] bias;

  assign bias  = CENTER_EN ? center_bias(mask) : '0;
  assign quant = (pix & mask) | bias;

endmodule

// File: rtl/hsv_threshold_quantizer.sv
// Streaming HSV quantizer with a two-stage valid/ready pipeline.
//   clk, reset                        : clock; asynchronous active-high reset
//   hThreshold/sThreshold/vThreshold  : live channel masks, captured on each
//                                       accepted start-of-frame beat
//   in_valid/in_ready/in_sof, h/s/v_in  : input stream
//   out_valid/out_ready/out_sof, h/s/v_out : quantized output stream
//   frame_pixels                      : accepted-beat count of the previous frame
module hsv_threshold_quantizer
  import hsv_threshold_quantizer_pkg::*;
#(
  parameter bit              CENTER_EN  = 1'b1,
  parameter logic [CH_W-1:0] H_RST_MASK = H_RST_MASK_DEF,
  parameter logic [CH_W-1:0] S_RST_MASK = S_RST_MASK_DEF,
  parameter logic [CH_W-1:0] V_RST_MASK = V_RST_MASK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_W-1:0]   hThreshold,
  input  logic [CH_W-1:0]   sThreshold,
  input  logic [CH_W-1:0]   vThreshold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [CH_W-1:0]   h_in,
  input  logic [CH_W-1:0]   s_in,
  input  logic [CH_W-1:0]   v_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [CH_W-1:0]   h_out,
  output logic [CH_W-1:0]   s_out,
  output logic [CH_W-1:0]   v_out,
  output logic [CNT_W-1:0]  frame_pixels
);

  localparam hsv_t RST_MASK = '{h: H_RST_MASK, s: S_RST_MASK, v: V_RST_MASK};

  hsv_t             act_mask;
  hsv_t             eff_mask;
  hsv_t             s1_pix;
  hsv_t             s1_mask;
  hsv_t             quant;
  logic             s1_valid;
  logic             s1_sof;
  logic             s1_adv;
  logic             accept;
  logic             take_sof;
  logic [CNT_W-1:0] pix_cnt;

  // Stage 1 moves whenever stage 2 is empty or draining, so bubbles collapse.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;
  assign take_sof = accept && in_sof;

  // The sof beat itself must see the freshly captured thresholds, so bypass
  // the shadow register in the capture cycle.
  assign eff_mask = take_sof ? '{h: hThreshold, s: sThreshold, v: vThreshold}
                             : act_mask;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_mask <= RST_MASK;
    end else if (take_sof) begin
      act_mask <= eff_mask;
    end
  end

  // NOTE: data registers are reset along with the valids so out_* read 0
  // after reset; this is a handful of flops, not a memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_pix   <= '0;
      s1_mask  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pix  <= '{h: h_in & eff_mask.h, s: s_in & eff_mask.s, v: v_in & eff_mask.v};
        s1_mask <= eff_mask;
        s1_sof  <= in_sof;
      end
    end
  end

  hsv_quant_channel #(.CENTER_EN(CENTER_EN)) u_ch_h (
    .pix(s1_pix.h), .mask(s1_mask.h), .quant(quant.h)
  );
  hsv_quant_channel #(.CENTER_EN(CENTER_EN)) u_ch_s (
    .pix(s1_pix.s), .mask(s1_mask.s), .quant(quant.s)
  );
  hsv_quant_channel #(.CENTER_EN(CENTER_EN)) u_ch_v (
    .pix(s1_pix.v), .mask(s1_mask.v), .quant(quant.v)
  );

  // Output register: holds its contents while out_valid && !out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      h_out     <= '0;
      s_out     <= '0;
      v_out     <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sof <= s1_sof;
        h_out   <= quant.h;
        s_out   <= quant.s;
        v_out   <= quant.v;
      end
    end
  end

  // Counter restarts at 1 on a sof beat because that beat belongs to the new
  // frame; the previous total is published at the same time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt      <= '0;
      frame_pixels <= '0;
    end else if (take_sof) begin
      frame_pixels <= pix_cnt;
      pix_cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (accept && pix_cnt != CNT_MAX) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hsv_threshold_quantizer.sv
// Self-checking bench for hsv_threshold_quantizer. Two instances share the
// input stream: dut (CENTER_EN=1) and dut_nc (CENTER_EN=0).
module tb_hsv_threshold_quantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hThreshold, sThreshold, vThreshold;
  logic        in_valid, in_sof, out_ready;
  logic [7:0]  h_in, s_in, v_in;
  logic        in_ready, out_valid, out_sof;
  logic [7:0]  h_out, s_out, v_out;
  logic [19:0] frame_pixels;
  logic        n_ready, n_valid, n_sof;
  logic [7:0]  n_h, n_s, n_v;
  logic [19:0] n_frame;

  always #5 clk = ~clk;

  hsv_threshold_quantizer dut (
    .clk(clk), .reset(reset),
    .hThreshold(hThreshold), .sThreshold(sThreshold), .vThreshold(vThreshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .h_in(h_in), .s_in(s_in), .v_in(v_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .h_out(h_out), .s_out(s_out), .v_out(v_out),
    .frame_pixels(frame_pixels)
  );

  hsv_threshold_quantizer #(.CENTER_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset),
    .hThreshold(hThreshold), .sThreshold(sThreshold), .vThreshold(vThreshold),
    .in_valid(in_valid), .in_ready(n_ready), .in_sof(in_sof),
    .h_in(h_in), .s_in(s_in), .v_in(v_in),
    .out_valid(n_valid), .out_ready(out_ready), .out_sof(n_sof),
    .h_out(n_h), .s_out(n_s), .v_out(n_v),
    .frame_pixels(n_frame)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-beat expectations computed at acceptance time.
  typedef struct {
    logic [7:0] h, s, v;     // CENTER_EN = 1
    logic [7:0] h0, s0, v0;  // CENTER_EN = 0
    logic       sof;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_hm, m_sm, m_vm;
  int         m_cnt, m_frame, m_n, outs;
  bit         stall_prev;
  logic [7:0] p_h, p_s, p_v;
  logic       p_sof;

  function automatic logic [7:0] quant(input logic [7:0] x, input logic [7:0] mask,
                                       input bit center);
    int bias;
    bias = center ? (256 - int'(mask)) / 2 : 0;
    return (x & mask) | bias[7:0];
  endfunction

  task automatic model_reset();
    m_hm = 8'hE0; m_sm = 8'hC0; m_vm = 8'hC0;
    m_cnt = 0; m_frame = 0; m_n = 0;
    q.delete();
    stall_prev = 1'b0;
  endtask

  // One clock cycle: drive, sample mid-cycle, score, update model, advance.
  task automatic drive_cycle(input logic iv, input logic isof, input logic [7:0] h,
                             input logic [7:0] s, input logic [7:0] v,
                             input logic ordy, output bit acc);
    bit   exp_rdy;
    exp_t e;
    in_valid = iv; in_sof = isof; h_in = h; s_in = s; v_in = v; out_ready = ordy;
    #1;
    exp_rdy = !(m_n == 2 && !ordy);
    checks++;
    if (in_ready !== exp_rdy || n_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b/%b expected %b (in flight %0d)", in_ready, n_ready, exp_rdy, m_n);
    end
    checks++;
    if (frame_pixels !== 20'(m_frame) || n_frame !== 20'(m_frame)) begin
      errors++;
      $display("FAIL frame_pixels: got %0d/%0d expected %0d", frame_pixels, n_frame, m_frame);
    end
    if (stall_prev) begin
      checks++;
      if ({out_valid, out_sof, h_out, s_out, v_out} !== {1'b1, p_sof, p_h, p_s, p_v}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b sof=%b %h %h %h expected v=1 sof=%b %h %h %h",
                 out_valid, out_sof, h_out, s_out, v_out, p_sof, p_h, p_s, p_v);
      end
    end
    if (out_valid === 1'b1 && ordy) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h %h %h with no beat outstanding", h_out, s_out, v_out);
      end else begin
        e = q.pop_front();
        if ({out_sof, h_out, s_out, v_out} !== {e.sof, e.h, e.s, e.v} ||
            {n_valid, n_sof, n_h, n_s, n_v} !== {1'b1, e.sof, e.h0, e.s0, e.v0}) begin
          errors++;
          $display("FAIL output: got sof=%b %h %h %h / nc v=%b %h %h %h expected sof=%b %h %h %h / nc %h %h %h",
                   out_sof, h_out, s_out, v_out, n_valid, n_h, n_s, n_v,
                   e.sof, e.h, e.s, e.v, e.h0, e.s0, e.v0);
        end
      end
      outs++;
      m_n--;
    end
    stall_prev = (out_valid === 1'b1) && !ordy;
    p_h = h_out; p_s = s_out; p_v = v_out; p_sof = out_sof;
    acc = iv && (in_ready === 1'b1);
    if (acc) begin
      if (isof) begin
        m_hm = hThreshold; m_sm = sThreshold; m_vm = vThreshold;
        m_frame = m_cnt;
        m_cnt = 1;
      end else if (m_cnt < (1 << 20) - 1) begin
        m_cnt++;
      end
      e.h  = quant(h, m_hm, 1'b1); e.s  = quant(s, m_sm, 1'b1); e.v  = quant(v, m_vm, 1'b1);
      e.h0 = quant(h, m_hm, 1'b0); e.s0 = quant(s, m_sm, 1'b0); e.v0 = quant(v, m_vm, 1'b0);
      e.sof = isof;
      q.push_back(e);
      m_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (q.size() != 0 || m_n != 0); i++)
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still outstanding, expected 0", q.size());
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({out_valid, out_sof, h_out, s_out, v_out, frame_pixels, in_ready} !== {1'b0, 1'b0, 24'h0, 20'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b sof=%b %h %h %h fp=%0d rdy=%b expected v=0 sof=0 00 00 00 fp=0 rdy=1",
               out_valid, out_sof, h_out, s_out, v_out, frame_pixels, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_first_sof();
    bit acc;
    drive_cycle(1'b1, 1'b1, 8'h5B, 8'h7F, 8'hC3, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, expected 0", out_valid);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if ({out_valid, out_sof, h_out, s_out, v_out} !== {1'b1, 1'b1, 8'h50, 8'h60, 8'hE0}) begin
      errors++;
      $display("FAIL first_sof: got v=%b sof=%b %h %h %h expected v=1 sof=1 50 60 e0",
               out_valid, out_sof, h_out, s_out, v_out);
    end
    drain();
  endtask

  task automatic test_threshold_shadow();
    bit acc;
    hThreshold = 8'hFF; sThreshold = 8'h00; vThreshold = 8'hF0;
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, acc);
    drive_cycle(1'b1, 1'b1, 8'hAB, 8'hAB, 8'hAB, 1'b1, acc);
    hThreshold = 8'h80;
    drive_cycle(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, acc);
    checks++;
    if ({out_valid, h_out, s_out, v_out} !== {1'b1, 8'hAB, 8'h80, 8'hA8}) begin
      errors++;
      $display("FAIL shadow_sof: got v=%b %h %h %h expected v=1 ab 80 a8", out_valid, h_out, s_out, v_out);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if ({out_valid, h_out, s_out, v_out} !== {1'b1, 8'hFF, 8'h80, 8'hF8}) begin
      errors++;
      $display("FAIL shadow_midframe: got v=%b %h %h %h expected v=1 ff 80 f8", out_valid, h_out, s_out, v_out);
    end
    drain();
    hThreshold = 8'hE0; sThreshold = 8'hC0; vThreshold = 8'hC0;
  endtask

  task automatic test_back_to_back();
    bit acc;
    int sent = 0;
    int base = outs;
    for (int cyc = 0; cyc < 200 && sent < 8; cyc++) begin
      drive_cycle(1'b1, sent == 0, 8'h10 + 8'(sent), 8'h3C ^ 8'(sent * 7), 8'hF0 - 8'(sent),
                  (cyc % 4 == 0) || (cyc % 4 == 3), acc);
      if (acc) sent++;
    end
    drain();
    checks++;
    if (outs - base != 8) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs expected 8", outs - base);
    end
  endtask

  task automatic test_frame_count();
    bit acc;
    int sent = 0;
    for (int cyc = 0; cyc < 1000 && sent < 300; cyc++) begin
      drive_cycle(1'b1, sent == 0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, acc);
      if (acc) sent++;
    end
    drive_cycle(1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1, acc);
    checks++;
    if (frame_pixels !== 20'd300) begin
      errors++;
      $display("FAIL frame_300: got %0d expected 300", frame_pixels);
    end
    drive_cycle(1'b1, 1'b1, 8'h44, 8'h55, 8'h66, 1'b1, acc);
    drive_cycle(1'b1, 1'b1, 8'h77, 8'h88, 8'h99, 1'b1, acc);
    checks++;
    if (frame_pixels !== 20'd1) begin
      errors++;
      $display("FAIL frame_b2b_sof: got %0d expected 1", frame_pixels);
    end
    drain();
  endtask

  task automatic test_random();
    bit         acc, pend, p_sof_in;
    logic [7:0] ph, ps, pv, m;
    pend = 1'b0; p_sof_in = 1'b0; ph = 0; ps = 0; pv = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        m = 8'hFF;
        hThreshold = m << $urandom_range(0, 8);
        sThreshold = m << $urandom_range(0, 8);
        vThreshold = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (m << $urandom_range(0, 8));
      end
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        p_sof_in = ($urandom_range(0, 11) == 0);
        ph = 8'($urandom); ps = 8'($urandom); pv = 8'($urandom);
      end
      if (pend)
        drive_cycle(1'b1, p_sof_in, ph, ps, pv, $urandom_range(0, 2) != 0, acc);
      else
        drive_cycle(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 2) != 0, acc);
      if (acc) pend = 1'b0;
    end
    drain();
    hThreshold = 8'hE0; sThreshold = 8'hC0; vThreshold = 8'hC0;
  endtask

  task automatic test_reset_midstream();
    bit acc;
    drive_cycle(1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 1'b0, acc);
    drive_cycle(1'b1, 1'b0, 8'h04, 8'h05, 8'h06, 1'b0, acc);
    drive_cycle(1'b1, 1'b0, 8'h07, 8'h08, 8'h09, 1'b0, acc);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || n_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: got out_valid=%b/%b in_ready=%b expected 0/0 1", out_valid, n_valid, in_ready);
    end
    hThreshold = 8'hFF; sThreshold = 8'hFF; vThreshold = 8'hFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive_cycle(1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1, acc);
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if ({out_valid, h_out, s_out, v_out} !== {1'b1, 8'h10, 8'h20, 8'h60}) begin
      errors++;
      $display("FAIL post_reset_masks: got v=%b %h %h %h expected v=1 10 20 60", out_valid, h_out, s_out, v_out);
    end
    drain();
    hThreshold = 8'hE0; sThreshold = 8'hC0; vThreshold = 8'hC0;
  endtask

  task automatic test_center_disabled();
    bit acc;
    apply_reset();
    drive_cycle(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, acc);
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if ({n_valid, n_h, n_s, n_v} !== {1'b1, 8'hE0, 8'hC0, 8'hC0}) begin
      errors++;
      $display("FAIL center_disabled: got v=%b %h %h %h expected v=1 e0 c0 c0", n_valid, n_h, n_s, n_v);
    end
    checks++;
    if ({out_valid, h_out, s_out, v_out} !== {1'b1, 8'hF0, 8'hE0, 8'hE0}) begin
      errors++;
      $display("FAIL center_enabled_ff: got v=%b %h %h %h expected v=1 f0 e0 e0", out_valid, h_out, s_out, v_out);
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    hThreshold = 8'hE0; sThreshold = 8'hC0; vThreshold = 8'hC0;
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    h_in = 8'h00; s_in = 8'h00; v_in = 8'h00;
    outs = 0;
    model_reset();
    test_reset();
    test_first_sof();
    test_threshold_shadow();
    test_back_to_back();
    test_frame_count();
    test_random();
    test_reset_midstream();
    test_center_disabled();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
